// File: rtl/systolic_output_deskew.sv
// Realigns the diagonally skewed result rows leaving a systolic array.
// Lane i waits length-i cycles so every lane of a row lands on dout at once.
module systolic_output_deskew #(
  parameter int DATA_WIDTH = 16,
  parameter int length     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH*length-1:0] din,
  input  logic [length-1:0]            valid_in,
  output logic [DATA_WIDTH*length-1:0] dout,
  output logic                         valid_out,
  output logic                         last_out,
  output logic [$clog2(length)-1:0]    row_idx,
  output logic                         skew_err
);

  localparam int IW = $clog2(length);
  localparam logic [IW-1:0] LAST = IW'(length - 1);

  logic [length-1:0] vpipe;
  logic [length-2:0] warm;
  logic [IW-1:0]     cnt;
  logic              mis;

  for (genvar i = 0; i < length; i++) begin : g_lane
    localparam int D = length - i;
    logic [DATA_WIDTH-1:0] sr [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < D; j++)
          sr[j] <= '0;
      end else begin
        sr[0] <= din[i*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < D; j++)
          sr[j] <= sr[j-1];
      end
    end

    assign dout[i*DATA_WIDTH +: DATA_WIDTH] = sr[D-1];
  end

  // vpipe[k] is lane-0 valid delayed k+1 cycles: both the row
  // valid pipe and the reference for the per-lane skew check.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[length-2:0], valid_in[0]};
    end
  end

  assign valid_out = vpipe[length-1];

  // warm[i-1] arms lane i once its history reaches past the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= '0;
    end else begin
      warm[0] <= 1'b1;
      for (int j = 1; j < length - 1; j++)
        warm[j] <= warm[j-1];
    end
  end

  always_comb begin
    mis = 1'b0;
    for (int i = 1; i < length; i++)
      if (warm[i-1] && (valid_in[i] != vpipe[i-1]))
        mis = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skew_err <= 1'b0;
    end else if (mis) begin
      skew_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (valid_out) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign row_idx  = cnt;
  assign last_out = valid_out & (cnt == LAST);

endmodule

// File: doc/systolic_output_deskew.md
SYSTOLIC_OUTPUT_DESKEW -- requirements
Module: systolic_output_deskew

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bit width of one result lane.
REQ-002 SHALL have parameter length, default 16: number of lanes (array columns), minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port din, input, DATA_WIDTH*length: skewed results; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port valid_in, input, length: per-lane valid; bit i qualifies lane i of din.
REQ-007 SHALL have port dout, output, DATA_WIDTH*length: deskewed row, same lane packing as din.
REQ-008 SHALL have port valid_out, output, 1: dout holds a complete aligned row.
REQ-009 SHALL have port last_out, output, 1: valid row is row index length-1 of the current tile.
REQ-010 SHALL have port row_idx, output, $clog2(length): index of the row currently on dout.
REQ-011 SHALL have port skew_err, output, 1: sticky lane-valid misalignment flag.

Function
REQ-012 Input skew model: row r lane i is presented i cycles after row r lane 0; valid_in[i] follows the same skew.
REQ-013 Lane i SHALL pass through exactly length-i registers, the final one being the dout register; lane length-1 SHALL enter the dout register directly.
REQ-014 A row whose lane 0 is sampled at edge k SHALL appear complete on dout, with valid_out=1, after edge k+length-1; latency is fixed at length-1 cycles from lane 0.
REQ-015 valid_out SHALL be valid_in[0] delayed by length registers, aligned with dout.
REQ-016 Data registers SHALL shift every cycle regardless of valid; dout content is defined only when valid_out=1.
REQ-017 Back-to-back rows (valid_in[0] high every cycle) SHALL produce valid_out high every cycle; gaps of any length SHALL be preserved exactly at the output.
REQ-018 Row counter: increments on each cycle with valid_out=1; row_idx SHALL equal the counter value for the row on dout.
REQ-019 last_out SHALL equal valid_out AND (row_idx == length-1); the counter SHALL wrap to 0 after that row.
REQ-020 Lane check: for each i>0, valid_in[i] SHALL equal valid_in[0] delayed by i cycles; a mismatch SHALL set skew_err on the following edge.
REQ-021 skew_err SHALL remain 1 until reset; a row containing a mismatch still flows through unchanged.
REQ-022 The lane check SHALL be suppressed for lane i during the first i cycles after reset deassertion (history not yet valid).
REQ-023 Data width: no arithmetic on data; lanes are carried bit-exact, no truncation or extension.

Reset
REQ-024 While rst=1 at an edge, all delay-line registers, dout, valid_out, last_out, row_idx and skew_err SHALL be cleared to 0.
REQ-025 Reset mid-stream SHALL discard all in-flight partial rows; no valid_out SHALL occur for rows whose lane 0 was sampled before the reset edge.
REQ-026 The first row whose lane 0 is sampled after reset SHALL have row_idx 0.

Verification
REQ-027 Single row: length=16, DW=16, lane i value 0x0100+i presented at edge k+i with valid_in[i]=1 -> after edge k+15, dout lanes 0..15 = 0x0100..0x010F, valid_out=1 for exactly one cycle, row_idx=0, last_out=0.
REQ-028 Full tile back-to-back: 16 skewed rows, row r lane i = r*16+i -> valid_out high 16 consecutive cycles, row_idx 0..15, last_out only on row 15, then row_idx wraps to 0.
REQ-029 Gapped stream: rows 0,1 then 3 idle cycles then row 2 -> valid_out pattern 1,1,0,0,0,1 with data bit-exact.
REQ-030 Skew fault: valid_in[5] asserted one cycle early for row 0 -> skew_err=1 after the next edge and held; row data still emerges at latency 15.
REQ-031 Reset mid-stream: rst=1 for one edge while 3 rows are in flight -> all outputs 0, no stale valid_out; the next row emerges with row_idx=0, skew_err=0.
REQ-032 Post-reset guard: apply reset, then immediately stream rows -> skew_err stays 0 through the first 15 cycles.
